spu_fetch_unit: RTL and testbench

- Dual-issue instruction fetch stage of the SPU pipeline; the producer side of the IF/ID pipeline register.
- Keeps the fetch PC and issues one 64-bit (two-instruction) request at a time to instruction memory. Each returned pair is presented with its next-sequential PC (fetch PC + 8).
- Handles hazard-unit stall (skid buffer, outputs held) and branch redirect (flush, discard in-flight data, odd-word target alignment).
- Drives NOP bubbles whenever no valid pair is presented.

---
 rtl/spu_fetch_unit_if.sv | 23 ++
 rtl/spu_fetch_unit.sv | 146 ++++++++++++++
 tb/tb_spu_fetch_unit.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spu_fetch_unit_if.sv
// Instruction-memory read port between the SPU fetch unit (master) and instruction memory (slave).
interface spu_fetch_unit_if #(
    parameter int unsigned PCbitsize = 11
);
    logic                 imem_req;
    logic [PCbitsize-1:0] imem_addr;
    logic                 imem_rvalid;
    logic [63:0]          imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/spu_fetch_unit.sv
// SPU dual-issue fetch stage: one 64-bit imem read in flight, skid buffer for hazard stalls,
// branch redirect with in-flight discard and odd-word target alignment.
module spu_fetch_unit #(
    parameter int unsigned PCbitsize = 11,
    parameter logic [31:0] NOP       = 32'h40200000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 branch_taken,
    input  logic [PCbitsize-1:0] branch_target,
    spu_fetch_unit_if.master     imem,
    output logic [PCbitsize-1:0] PC_adderOut,
    output logic [31:0]          instruction1,
    output logic [31:0]          instruction2,
    output logic                 fetch_valid
);
    typedef enum logic [1:0] {StIdle, StReq, StWait, StFull} state_e;

    state_e               r_state;
    logic [PCbitsize-1:0] r_fetch_pc;
    logic                 r_discard;
    logic                 r_misalign;
    logic                 r_req;
    logic [31:0]          r_skid_i1;
    logic [31:0]          r_skid_i2;
    logic [PCbitsize-1:0] r_skid_pc;
    logic [31:0]          r_i1;
    logic [31:0]          r_i2;
    logic [PCbitsize-1:0] r_pc_out;
    logic                 r_valid;

    logic [PCbitsize-1:0] w_pc_next;
    logic [PCbitsize-1:0] w_target_aligned;
    logic [31:0]          w_pair_i1;
    logic                 w_unused;

    assign w_pc_next        = r_fetch_pc + PCbitsize'(8);
    assign w_target_aligned = {branch_target[PCbitsize-1:3], 3'b000};
    // A misaligned redirect target lands in the younger slot; the older slot is a bubble.
    assign w_pair_i1        = r_misalign ? NOP : imem.imem_rdata[63:32];
    assign w_unused         = ^branch_target[1:0];

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= StIdle;
            r_fetch_pc <= '0;
            r_discard  <= 1'b0;
            r_misalign <= 1'b0;
            r_req      <= 1'b0;
            r_skid_i1  <= NOP;
            r_skid_i2  <= NOP;
            r_skid_pc  <= '0;
            r_i1       <= NOP;
            r_i2       <= NOP;
            r_pc_out   <= '0;
            r_valid    <= 1'b0;
        end else begin
            r_req <= 1'b0;
            if (!stall) begin
                r_i1    <= NOP;
                r_i2    <= NOP;
                r_valid <= 1'b0;
            end
            if (branch_taken) begin
                r_fetch_pc <= w_target_aligned;
                r_misalign <= branch_target[2];
                r_i1       <= NOP;
                r_i2       <= NOP;
                r_valid    <= 1'b0;
                case (r_state)
                    StReq: begin
                        r_state   <= StWait;
                        r_discard <= 1'b1;
                    end
                    StWait: begin
                        if (imem.imem_rvalid) begin
                            r_state   <= StReq;
                            r_req     <= 1'b1;
                            r_discard <= 1'b0;
                        end else begin
                            r_state   <= StWait;
                            r_discard <= 1'b1;
                        end
                    end
                    default: begin
                        r_state   <= StReq;
                        r_req     <= 1'b1;
                        r_discard <= 1'b0;
                    end
                endcase
            end else begin
                case (r_state)
                    StIdle: begin
                        r_state <= StReq;
                        r_req   <= 1'b1;
                    end
                    StReq: r_state <= StWait;
                    StWait: begin
                        if (imem.imem_rvalid) begin
                            if (r_discard) begin
                                r_discard <= 1'b0;
                                r_state   <= StReq;
                                r_req     <= 1'b1;
                            end else if (!stall) begin
                                r_i1       <= w_pair_i1;
                                r_i2       <= imem.imem_rdata[31:0];
                                r_pc_out   <= w_pc_next;
                                r_valid    <= 1'b1;
                                r_fetch_pc <= w_pc_next;
                                r_misalign <= 1'b0;
                                r_state    <= StReq;
                                r_req      <= 1'b1;
                            end else begin
                                r_skid_i1  <= w_pair_i1;
                                r_skid_i2  <= imem.imem_rdata[31:0];
                                r_skid_pc  <= w_pc_next;
                                r_misalign <= 1'b0;
                                r_state    <= StFull;
                            end
                        end
                    end
                    StFull: begin
                        if (!stall) begin
                            r_i1       <= r_skid_i1;
                            r_i2       <= r_skid_i2;
                            r_pc_out   <= r_skid_pc;
                            r_valid    <= 1'b1;
                            r_fetch_pc <= r_skid_pc;
                            r_state    <= StReq;
                            r_req      <= 1'b1;
                        end
                    end
                    default: r_state <= StIdle;
                endcase
            end
        end
    end

    assign imem.imem_req  = r_req;
    assign imem.imem_addr = {r_fetch_pc[PCbitsize-1:3], 3'b000};
    assign PC_adderOut    = r_pc_out;
    assign instruction1   = r_i1;
    assign instruction2   = r_i2;
    assign fetch_valid    = r_valid;
endmodule

// File: tb/tb_spu_fetch_unit.sv
// Bench for spu_fetch_unit: directed stimulus, variable-latency memory, and a queue-based
// model of accepted-but-unpresented pairs checked against the outputs every cycle.
module tb_spu_fetch_unit;
    localparam int unsigned PCbitsize = 11;
    localparam logic [31:0] NOP       = 32'h40200000;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 stall;
    logic                 branch_taken;
    logic [PCbitsize-1:0] branch_target;
    logic [PCbitsize-1:0] PC_adderOut;
    logic [31:0]          instruction1;
    logic [31:0]          instruction2;
    logic                 fetch_valid;

    spu_fetch_unit_if #(.PCbitsize(PCbitsize)) imem ();

    spu_fetch_unit #(.PCbitsize(PCbitsize), .NOP(NOP)) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .imem         (imem),
        .PC_adderOut  (PC_adderOut),
        .instruction1 (instruction1),
        .instruction2 (instruction2),
        .fetch_valid  (fetch_valid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, got, want, $time);
    endtask

    // Memory image: every word holds 0x1000_0000 | its byte address.
    function automatic logic [31:0] word_at(input logic [PCbitsize-1:0] a);
        return 32'h1000_0000 | 32'(a);
    endfunction

    typedef struct packed {
        logic [31:0]          i1;
        logic [31:0]          i2;
        logic [PCbitsize-1:0] pc;
    } pair_t;

    int                   mem_lat = 1;
    bit                   pend    = 1'b0;
    int                   cnt     = 0;
    logic [PCbitsize-1:0] paddr;
    bit                   seen_req = 1'b0;
    bit                   ready    = 1'b0;

    pair_t                q[$];
    bit                   outstanding = 1'b0;
    bit                   stale       = 1'b0;
    bit                   mis         = 1'b0;
    logic [PCbitsize-1:0] exp_pc      = '0;
    logic [31:0]          e_i1        = NOP;
    logic [31:0]          e_i2        = NOP;
    logic [PCbitsize-1:0] e_pc        = '0;
    logic                 e_valid     = 1'b0;

    // Memory responder and per-cycle compare, both away from the active edge.
    always @(negedge clk) begin
        imem.imem_rvalid = 1'b0;
        if (pend) begin
            cnt--;
            if (cnt == 0) begin
                imem.imem_rvalid = 1'b1;
                imem.imem_rdata  = {word_at(paddr), word_at(paddr + PCbitsize'(4))};
                pend = 1'b0;
            end
        end
        seen_req = (imem.imem_req === 1'b1);
        if (ready) begin
            check("outputs_instr", {instruction1, instruction2}, {e_i1, e_i2});
            check("outputs_pc_valid", {PC_adderOut, fetch_valid}, {e_pc, e_valid});
            if (seen_req) begin
                check("req_single_outstanding", outstanding, 1'b0);
                check("req_addr", imem.imem_addr, exp_pc);
            end
        end
        if (seen_req) begin
            pend  = 1'b1;
            cnt   = mem_lat;
            paddr = imem.imem_addr;
        end
    end

    // Model: each accepted response joins a queue; every un-stalled edge presents the oldest
    // queued pair or a bubble; a stall holds; a redirect flushes and poisons any in-flight read.
    always @(posedge clk) begin
        bit    resp;
        pair_t p;
        if (!reset) begin
            q.delete();
            outstanding = 1'b0;
            stale       = 1'b0;
            mis         = 1'b0;
            exp_pc      = '0;
            e_i1        = NOP;
            e_i2        = NOP;
            e_pc        = '0;
            e_valid     = 1'b0;
            ready       = 1'b1;
        end else if (ready) begin
            resp = (imem.imem_rvalid === 1'b1) && outstanding;
            if (branch_taken) begin
                q.delete();
                if (resp) begin
                    outstanding = 1'b0;
                    stale       = 1'b0;
                end else if (outstanding || seen_req) begin
                    stale = 1'b1;
                end
                exp_pc  = {branch_target[PCbitsize-1:3], 3'b000};
                mis     = branch_target[2];
                e_i1    = NOP;
                e_i2    = NOP;
                e_valid = 1'b0;
            end else begin
                if (resp) begin
                    outstanding = 1'b0;
                    if (stale) begin
                        stale = 1'b0;
                    end else begin
                        p.i1   = mis ? NOP : imem.imem_rdata[63:32];
                        p.i2   = imem.imem_rdata[31:0];
                        p.pc   = exp_pc + PCbitsize'(8);
                        q.push_back(p);
                        exp_pc = p.pc;
                        mis    = 1'b0;
                    end
                end
                if (!stall) begin
                    if (q.size() > 0) begin
                        p       = q.pop_front();
                        e_i1    = p.i1;
                        e_i2    = p.i2;
                        e_pc    = p.pc;
                        e_valid = 1'b1;
                    end else begin
                        e_i1    = NOP;
                        e_i2    = NOP;
                        e_valid = 1'b0;
                    end
                end
            end
            if (seen_req) outstanding = 1'b1;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name, input int max_cycles);
        int i = 0;
        while (fetch_valid !== 1'b1 && i < max_cycles) begin
            tick();
            i++;
        end
        check(name, fetch_valid === 1'b1, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset         = 1'b0;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = '0;
        tick();
        tick();
        check("rst_instr", {instruction1, instruction2}, {NOP, NOP});
        check("rst_pc_valid_req", {PC_adderOut, fetch_valid, imem.imem_req}, {11'h000, 2'b00});
        reset = 1'b1;

        // Back-to-back sequential fetch, 1-cycle memory.
        tick();
        check("t1_req000", {imem.imem_req, imem.imem_addr}, {1'b1, 11'h000});
        tick();
        tick();
        check("t1_pairAB", {instruction1, instruction2, PC_adderOut, fetch_valid},
              {32'h1000_0000, 32'h1000_0004, 11'h008, 1'b1});
        check("t1_req008", {imem.imem_req, imem.imem_addr}, {1'b1, 11'h008});
        tick();
        check("t1_bubble", {fetch_valid, instruction1, instruction2}, {1'b0, NOP, NOP});
        tick();
        check("t1_pairCD", {instruction1, instruction2, PC_adderOut, fetch_valid},
              {32'h1000_0008, 32'h1000_000C, 11'h010, 1'b1});

        // Stall as the first pair returns: held in the skid buffer for three cycles.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        check("t2_req000", {imem.imem_req, imem.imem_addr}, {1'b1, 11'h000});
        tick();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t2_full_hold", {imem.imem_req, fetch_valid, instruction1, instruction2},
                  {2'b00, NOP, NOP});
        end
        stall = 1'b0;
        tick();
        check("t2_release", {instruction1, instruction2, PC_adderOut, fetch_valid},
              {32'h1000_0000, 32'h1000_0004, 11'h008, 1'b1});
        check("t2_req008", {imem.imem_req, imem.imem_addr}, {1'b1, 11'h008});

        // Redirect to a misaligned target while the read of 0x010 is in flight.
        tick();
        mem_lat = 2;
        tick();
        check("t3_req010", {imem.imem_req, imem.imem_addr}, {1'b1, 11'h010});
        tick();
        branch_taken  = 1'b1;
        branch_target = 11'h104;
        tick();
        branch_taken = 1'b0;
        check("t3_flush", {fetch_valid, instruction1, instruction2}, {1'b0, NOP, NOP});
        tick();
        check("t3_req100", {imem.imem_req, imem.imem_addr}, {1'b1, 11'h100});
        wait_valid("t3_wait_pair", 10);
        check("t3_pair_misaligned", {instruction1, instruction2, PC_adderOut},
              {NOP, 32'h1000_0104, 11'h108});
        check("t3_req108", {imem.imem_req, imem.imem_addr}, {1'b1, 11'h108});

        // Wrap of the fetch PC at the top of the address space.
        mem_lat       = 1;
        branch_taken  = 1'b1;
        branch_target = 11'h7F0;
        tick();
        branch_taken = 1'b0;
        wait_valid("t4_wait_7f0", 20);
        check("t4_pair7f0", {instruction1, instruction2, PC_adderOut},
              {32'h1000_07F0, 32'h1000_07F4, 11'h7F8});
        tick();
        wait_valid("t4_wait_7f8", 20);
        check("t4_pair7f8_wrap", {instruction1, instruction2, PC_adderOut},
              {32'h1000_07F8, 32'h1000_07FC, 11'h000});
        check("t4_req_wrap", {imem.imem_req, imem.imem_addr}, {1'b1, 11'h000});

        // Redirect together with stall while the skid buffer is full.
        tick();
        stall = 1'b1;
        tick();
        check("t5_full_noreq", imem.imem_req, 1'b0);
        branch_taken  = 1'b1;
        branch_target = 11'h200;
        tick();
        branch_taken = 1'b0;
        stall        = 1'b0;
        check("t5_flush", {fetch_valid, instruction1, instruction2}, {1'b0, NOP, NOP});
        check("t5_req200", {imem.imem_req, imem.imem_addr}, {1'b1, 11'h200});
        wait_valid("t5_wait_pair", 10);
        check("t5_pair200", {instruction1, instruction2, PC_adderOut},
              {32'h1000_0200, 32'h1000_0204, 11'h208});

        // Reset while waiting; the late response must be ignored.
        mem_lat = 2;
        tick();
        tick();
        check("t6_req210", {imem.imem_req, imem.imem_addr}, {1'b1, 11'h210});
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("t6_rst_out", {fetch_valid, PC_adderOut, instruction1, instruction2},
              {1'b0, 11'h000, NOP, NOP});
        check("t6_rst_noreq", imem.imem_req, 1'b0);
        tick();
        check("t6_req000", {imem.imem_req, imem.imem_addr, fetch_valid}, {1'b1, 11'h000, 1'b0});
        wait_valid("t6_wait_pair", 10);
        check("t6_pair000", {instruction1, instruction2, PC_adderOut},
              {32'h1000_0000, 32'h1000_0004, 11'h008});

        tick();
        tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
